// File: rtl/db_param_pkg.sv
// Shared constants and type definitions for the deblocking beta arbiter.
package db_param_pkg;

    localparam int QP_W   = 6;
    localparam int BETA_W = 7;
    localparam int OFF_W  = 4;
    localparam int QP_MAX = 51;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    typedef enum logic {
        SRC_VER = 1'b0,
        SRC_HOR = 1'b1
    } src_e;

endpackage

// File: rtl/db_lut_beta.sv
// Combinational beta table: maps a clipped Q index (0..51) to beta.
module db_lut_beta
    import db_param_pkg::*;
(
    input  logic [QP_W-1:0]   qp_i,
    output logic [BETA_W-1:0] beta_o
);

    // Table lookup; Q below 16 and out-of-range indices give zero.
    always_comb begin
        beta_o = '0;
        case (qp_i)
            6'd16: beta_o = 7'd6;   6'd17: beta_o = 7'd7;   6'd18: beta_o = 7'd8;
            6'd19: beta_o = 7'd9;   6'd20: beta_o = 7'd10;  6'd21: beta_o = 7'd11;
            6'd22: beta_o = 7'd12;  6'd23: beta_o = 7'd13;  6'd24: beta_o = 7'd14;
            6'd25: beta_o = 7'd15;  6'd26: beta_o = 7'd16;  6'd27: beta_o = 7'd17;
            6'd28: beta_o = 7'd18;  6'd29: beta_o = 7'd20;  6'd30: beta_o = 7'd22;
            6'd31: beta_o = 7'd24;  6'd32: beta_o = 7'd26;  6'd33: beta_o = 7'd28;
            6'd34: beta_o = 7'd30;  6'd35: beta_o = 7'd32;  6'd36: beta_o = 7'd34;
            6'd37: beta_o = 7'd36;  6'd38: beta_o = 7'd38;  6'd39: beta_o = 7'd40;
            6'd40: beta_o = 7'd42;  6'd41: beta_o = 7'd44;  6'd42: beta_o = 7'd46;
            6'd43: beta_o = 7'd48;  6'd44: beta_o = 7'd50;  6'd45: beta_o = 7'd52;
            6'd46: beta_o = 7'd54;  6'd47: beta_o = 7'd56;  6'd48: beta_o = 7'd58;
            6'd49: beta_o = 7'd60;  6'd50: beta_o = 7'd62;  6'd51: beta_o = 7'd64;
            default: beta_o = '0;
        endcase
    end

endmodule

// File: rtl/db_beta_arb.sv
// Two-requester beta lookup arbiter: grants a vertical or horizontal edge,
// computes the clipped Q index from the captured QPs and offset, and
// presents the looked-up beta with a valid/ready handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no result pending; a request is granted and captured here
//   ST_CALC | captured operands -> clipped Q -> beta register (one cycle)
//   ST_OUT  | result valid; held until ready, may grant the next request
module db_beta_arb
    import db_param_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OFF_W-1:0]  beta_offset_div2_i,
    input  logic              ver_req_i,
    input  logic              hor_req_i,
    input  logic [QP_W-1:0]   ver_qp_p_i,
    input  logic [QP_W-1:0]   ver_qp_q_i,
    input  logic [QP_W-1:0]   hor_qp_p_i,
    input  logic [QP_W-1:0]   hor_qp_q_i,
    output logic              ver_ack_o,
    output logic              hor_ack_o,
    output logic              beta_valid_o,
    input  logic              beta_ready_i,
    output logic [BETA_W-1:0] beta_o,
    output logic [QP_W-1:0]   qp_o,
    output logic              src_o
);

    state_e             state_q;
    src_e               last_grant_q;
    src_e               cap_src_q;
    logic               started_q;
    logic [QP_W-1:0]    cap_p_q;
    logic [QP_W-1:0]    cap_q_q;
    logic [OFF_W-1:0]   cap_off_q;
    logic [BETA_W-1:0]  beta_q;
    logic [QP_W-1:0]    qp_out_q;
    logic               src_out_q;
    logic               valid_q;

    logic               can_grant;
    logic               grant_ver;
    logic               grant_hor;
    logic               ver_ack;
    logic               hor_ack;
    logic               any_ack;

    logic [QP_W:0]      qp_sum;
    logic [QP_W-1:0]    qp_avg;
    logic [7:0]         q_raw;
    logic [QP_W-1:0]    q_clip;
    logic [BETA_W-1:0]  lut_beta;

    // Grant decision; the ack is combinational so operands are captured in
    // the same cycle the requester sees it. started_q keeps the first cycle
    // after reset release free of acks.
    always_comb begin
        can_grant = started_q &&
                    ((state_q == ST_IDLE) || ((state_q == ST_OUT) && beta_ready_i));
        grant_hor = hor_req_i && (!ver_req_i || (last_grant_q == SRC_VER));
        grant_ver = ver_req_i && !grant_hor;
        ver_ack   = can_grant && grant_ver;
        hor_ack   = can_grant && grant_hor;
        any_ack   = ver_ack || hor_ack;
    end

    // Rounded QP average plus doubled signed offset, saturated to 0..QP_MAX.
    always_comb begin
        qp_sum = {1'b0, cap_p_q} + {1'b0, cap_q_q} + 7'd1;
        qp_avg = qp_sum[QP_W:1];
        q_raw  = {2'b00, qp_avg} + {{3{cap_off_q[OFF_W-1]}}, cap_off_q, 1'b0};
        if (q_raw[7]) begin
            q_clip = '0;
        end else if (q_raw[6:0] > 7'(QP_MAX)) begin
            q_clip = QP_W'(QP_MAX);
        end else begin
            q_clip = q_raw[QP_W-1:0];
        end
    end

    db_lut_beta u_lut_beta (
        .qp_i   (q_clip),
        .beta_o (lut_beta)
    );

    // Arbiter FSM with operand capture and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= SRC_HOR;
            cap_src_q    <= SRC_VER;
            started_q    <= 1'b0;
            cap_p_q      <= '0;
            cap_q_q      <= '0;
            cap_off_q    <= '0;
            beta_q       <= '0;
            qp_out_q     <= '0;
            src_out_q    <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            started_q <= 1'b1;
            if (any_ack) begin
                cap_p_q      <= hor_ack ? hor_qp_p_i : ver_qp_p_i;
                cap_q_q      <= hor_ack ? hor_qp_q_i : ver_qp_q_i;
                cap_off_q    <= beta_offset_div2_i;
                cap_src_q    <= hor_ack ? SRC_HOR : SRC_VER;
                last_grant_q <= hor_ack ? SRC_HOR : SRC_VER;
            end
            case (state_q)
                ST_IDLE: begin
                    if (any_ack) begin
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    beta_q    <= lut_beta;
                    qp_out_q  <= q_clip;
                    src_out_q <= cap_src_q;
                    valid_q   <= 1'b1;
                    state_q   <= ST_OUT;
                end
                ST_OUT: begin
                    if (beta_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= any_ack ? ST_CALC : ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ver_ack_o    = ver_ack;
    assign hor_ack_o    = hor_ack;
    assign beta_valid_o = valid_q;
    assign beta_o       = beta_q;
    assign qp_o         = qp_out_q;
    assign src_o        = src_out_q;

endmodule

// File: tb/tb_db_beta_arb.sv
// Self-checking bench for db_beta_arb: directed vector table, randomized
// transactions against a reference model, and hand-written corner sequences.
module tb_db_beta_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] beta_offset_div2;
    logic       ver_req, hor_req;
    logic [5:0] ver_qp_p, ver_qp_q, hor_qp_p, hor_qp_q;
    logic       ver_ack_o, hor_ack_o, beta_valid_o, src_o;
    logic       beta_ready;
    logic [6:0] beta_o;
    logic [5:0] qp_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    db_beta_arb dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .beta_offset_div2_i (beta_offset_div2),
        .ver_req_i          (ver_req),
        .hor_req_i          (hor_req),
        .ver_qp_p_i         (ver_qp_p),
        .ver_qp_q_i         (ver_qp_q),
        .hor_qp_p_i         (hor_qp_p),
        .hor_qp_q_i         (hor_qp_q),
        .ver_ack_o          (ver_ack_o),
        .hor_ack_o          (hor_ack_o),
        .beta_valid_o       (beta_valid_o),
        .beta_ready_i       (beta_ready),
        .beta_o             (beta_o),
        .qp_o               (qp_o),
        .src_o              (src_o)
    );

    typedef struct {
        bit src;
        int p;
        int q;
        int off;
        int exp_q;
        int exp_beta;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: rounded average, doubled offset, saturation, then the
    // beta curve as three straight-line segments.
    function automatic int ref_q(input int p, input int q, input int off);
        int r;
        r = (p + q + 1) / 2 + 2 * off;
        if (r < 0) r = 0;
        if (r > 51) r = 51;
        return r;
    endfunction

    function automatic int ref_beta(input int qi);
        if (qi < 16) return 0;
        if (qi < 29) return qi - 10;
        return 2 * qi - 38;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        ver_qp_p = 6'($urandom_range(0, 51));
        ver_qp_q = 6'($urandom_range(0, 51));
        hor_qp_p = 6'($urandom_range(0, 51));
        hor_qp_q = 6'($urandom_range(0, 51));
        beta_offset_div2 = 4'($urandom_range(0, 12) - 6);
    endtask

    // One request/result transaction; caller is at a negedge with the DUT idle
    // or about to leave OUT with ready high.
    task automatic transact(input bit src, input int p, input int q, input int off,
                            input int stall, input int exp_q, input int exp_beta,
                            input string tag);
        bit got;
        int wait_n;
        logic [6:0] b_hold;
        logic [5:0] q_hold;
        logic       s_hold;
        got = 0;
        wait_n = 0;
        tick();
        scramble();
        if (src) begin
            hor_qp_p = 6'(p); hor_qp_q = 6'(q);
        end else begin
            ver_qp_p = 6'(p); ver_qp_q = 6'(q);
        end
        beta_offset_div2 = 4'(off);
        ver_req = !src;
        hor_req = src;
        beta_ready = (stall == 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ver_ack_o || hor_ack_o) begin
                got = 1;
                wait_n = i;
                break;
            end
        end
        if (!got) begin
            check({tag, "_ack_timeout"}, 0, 1);
            ver_req = 0;
            hor_req = 0;
            beta_ready = 1;
            return;
        end
        check({tag, "_ack_latency"}, wait_n, 0);
        check({tag, "_ack_src"}, {ver_ack_o, hor_ack_o}, src ? 2'b01 : 2'b10);
        tick();
        ver_req = 0;
        hor_req = 0;
        scramble();
        @(negedge clk);
        check({tag, "_calc_valid"}, beta_valid_o, 0);
        tick();
        @(negedge clk);
        check({tag, "_valid"}, beta_valid_o, 1);
        check({tag, "_qp"}, qp_o, exp_q);
        check({tag, "_beta"}, beta_o, exp_beta);
        check({tag, "_src"}, src_o, src);
        b_hold = beta_o;
        q_hold = qp_o;
        s_hold = src_o;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (i == stall - 1) beta_ready = 1;
            @(negedge clk);
            check({tag, "_hold"}, {beta_valid_o, beta_o, qp_o, src_o, ver_ack_o, hor_ack_o},
                  {1'b1, b_hold, q_hold, s_hold, 2'b00});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit exp_last;
        bit got_q[$];
        int nacks;

        vecs[0]  = '{0, 30, 31,  0, 31, 24};
        vecs[1]  = '{1, 31, 31,  3, 37, 36};
        vecs[2]  = '{0,  4,  4, -6,  0,  0};
        vecs[3]  = '{1, 51, 51,  6, 51, 64};
        vecs[4]  = '{0, 15, 16,  0, 16,  6};
        vecs[5]  = '{1, 20, 25,  4, 31, 24};
        vecs[6]  = '{0, 28, 29, -1, 27, 17};
        vecs[7]  = '{1,  0,  1,  0,  1,  0};
        vecs[8]  = '{0, 50, 51,  1, 51, 64};
        vecs[9]  = '{1, 10, 11, -6,  0,  0};
        vecs[10] = '{0, 47, 48,  1, 50, 62};

        // Reset with both requesters already asking.
        rst_n = 0;
        beta_offset_div2 = 0;
        ver_qp_p = 0; ver_qp_q = 0; hor_qp_p = 0; hor_qp_q = 0;
        ver_req = 1;
        hor_req = 1;
        beta_ready = 1;
        #12;
        check("reset_outputs", {ver_ack_o, hor_ack_o, beta_valid_o, beta_o, qp_o, src_o}, 0);
        tick();
        rst_n = 1;
        @(negedge clk);
        check("first_cycle_after_release", {ver_ack_o, hor_ack_o, beta_valid_o}, 0);

        // Both held high: grants alternate starting with vertical.
        nacks = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check("ack_overlap", ver_ack_o & hor_ack_o, 0);
            if (ver_ack_o || hor_ack_o) begin
                got_q.push_back(hor_ack_o);
                nacks++;
            end
        end
        check("rr_grant_count", nacks, 5);
        exp_last = 1;
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            exp_last = !exp_last;
            check($sformatf("rr_grant%0d", i), got_q[i], exp_last);
        end
        tick();
        ver_req = 0;
        hor_req = 0;
        repeat (3) @(negedge clk);

        // Directed vector table.
        foreach (vecs[i]) begin
            transact(vecs[i].src, vecs[i].p, vecs[i].q, vecs[i].off, 0,
                     vecs[i].exp_q, vecs[i].exp_beta, $sformatf("vec%0d", i));
        end

        // Randomized transactions against the reference model.
        for (int n = 0; n < 40; n++) begin
            bit s;
            int p, q, off, st;
            s   = 1'($urandom_range(0, 1));
            p   = $urandom_range(0, 51);
            q   = $urandom_range(0, 51);
            off = $urandom_range(0, 12) - 6;
            st  = $urandom_range(0, 3);
            transact(s, p, q, off, st, ref_q(p, q, off), ref_beta(ref_q(p, q, off)),
                     $sformatf("rnd%0d", n));
        end

        // Back-pressure: five cycles of ready low with a pending horizontal request.
        tick();
        ver_qp_p = 10; ver_qp_q = 20; beta_offset_div2 = 4'd1;
        ver_req = 1;
        beta_ready = 0;
        @(negedge clk);
        check("bp_ver_ack", ver_ack_o, 1);
        tick();
        ver_req = 0;
        @(negedge clk);
        tick();
        hor_qp_p = 40; hor_qp_q = 42; beta_offset_div2 = 4'(-2);
        hor_req = 1;
        @(negedge clk);
        check("bp_first", {beta_valid_o, beta_o, qp_o, src_o}, {1'b1, 7'd7, 6'd17, 1'b0});
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("bp_held", {beta_valid_o, beta_o, qp_o, src_o, ver_ack_o, hor_ack_o},
                  {1'b1, 7'd7, 6'd17, 1'b0, 2'b00});
        end
        tick();
        beta_ready = 1;
        @(negedge clk);
        check("bp_release_ack", {hor_ack_o, beta_valid_o}, 2'b11);
        tick();
        hor_req = 0;
        @(negedge clk);
        check("bp_calc_valid", beta_valid_o, 0);
        tick();
        @(negedge clk);
        check("bp_hor_result", {beta_valid_o, beta_o, qp_o, src_o}, {1'b1, 7'd36, 6'd37, 1'b1});

        // Reset during CALC discards the in-flight result asynchronously.
        tick();
        ver_qp_p = 40; ver_qp_q = 40; beta_offset_div2 = 0;
        ver_req = 1;
        @(negedge clk);
        check("rst_mid_ack", ver_ack_o, 1);
        tick();
        check("rst_mid_pre", {beta_valid_o, beta_o, src_o}, {1'b0, 7'd36, 1'b1});
        rst_n = 0;
        #1;
        check("rst_mid_async", {ver_ack_o, hor_ack_o, beta_valid_o, beta_o, qp_o, src_o}, 0);
        tick();
        rst_n = 1;
        @(negedge clk);
        check("rst_mid_release", {ver_ack_o, hor_ack_o, beta_valid_o}, 0);
        transact(0, 40, 40, 0, 0, 40, 42, "post_reset");

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/db_beta_arb.md
DB_BETA_ARB -- requirements
Module: db_beta_arb

Interface
REQ-001 clk  in  1  Block clock; all state updates on its rising edge.
REQ-002 rst_n  in  1  Reset; asynchronous assert, active-low.
REQ-003 beta_offset_div2_i  in  4  Signed slice beta offset divided by 2; legal range -6..+6; sampled at grant.
REQ-004 ver_req_i / hor_req_i  in  1 each  Vertical-edge / horizontal-edge requester wants a beta lookup; held high until acked.
REQ-005 ver_qp_p_i, ver_qp_q_i, hor_qp_p_i, hor_qp_q_i  in  6 each  Unsigned P/Q block QPs (0..51), valid while the matching req is high.
REQ-006 ver_ack_o / hor_ack_o  out  1 each  One-cycle pulse; the requester's operands are captured in this cycle.
REQ-007 beta_valid_o  out  1  Result valid.
REQ-008 beta_ready_i  in  1  Consumer accepts the result when it is high together with beta_valid_o.
REQ-009 beta_o  out  7  Beta value for the granted edge.
REQ-010 qp_o  out  6  Clipped Q index used for the lookup.
REQ-011 src_o  out  1  Source of the result: 0 = vertical, 1 = horizontal.

Function
REQ-012 States: IDLE, CALC, OUT; encoding 2 bits.
REQ-013 IDLE: any req high -> grant one requester, pulse its ack, capture qp_p, qp_q, offset and src -> CALC; no req -> stay in IDLE.
REQ-014 Arbitration: single requester -> grant it; both requesting -> grant the requester not in last_grant; last_grant updates on every grant.
REQ-015 CALC: qp_avg = (qp_p + qp_q + 1) >> 1 computed with a 7-bit sum; Q = qp_avg + 2*offset in 8-bit signed arithmetic, clipped to 0..51.
REQ-016 CALC: beta_o <= lut(Q), qp_o <= Q, src_o <= captured src -> OUT; always exactly one cycle.
REQ-017 OUT: beta_valid_o = 1; beta_o, qp_o and src_o are held stable while beta_ready_i is low.
REQ-018 OUT with beta_ready_i high and no req -> IDLE; with a req -> grant in the same cycle (ack, capture) -> CALC.
REQ-019 Latency: ack in cycle T -> beta_valid_o high in cycle T+2; peak throughput is one result per 2 cycles.
REQ-020 At most one ack is high in any cycle; no ack is asserted in CALC, or in OUT while beta_ready_i is low.
REQ-021 beta_valid_o is a registered state decode, never combinational from inputs.
REQ-022 Requests deasserted before ack are dropped without side effects.

Reset
REQ-023 On rst_n low: state = IDLE, last_grant = 1 (horizontal, so vertical wins the first tie), beta_o = 0, qp_o = 0, src_o = 0, beta_valid_o = 0, acks = 0.
REQ-024 Reset asserted in CALC or OUT discards the in-flight result; no ack or valid is produced in the first cycle after release.

Structure
REQ-025 Shared package db_param_pkg holds the state encoding, QP_MAX = 51, QP_W = 6, BETA_W = 7 and the src codes.
REQ-026 One sub-module: the existing combinational db_lut_beta, instantiated once and driven by the clipped Q.
REQ-027 Target size: 120-400 lines of RTL; no memories; a single clock domain.

Verification
REQ-028 Offset 0, ver qp_p = 30, qp_q = 31 -> Q = 31, beta_o = 24, src_o = 0, valid at T+2.
REQ-029 Offset +3, hor qp_p = qp_q = 31 -> Q = 37, beta_o = 36; offset -6, qp = 4/4 -> Q = 0, beta_o = 0; offset +6, qp = 51/51 -> Q = 51, beta_o = 64.
REQ-030 Both reqs held high after reset with beta_ready_i = 1 -> grant order ver, hor, ver, hor; acks never overlap.
REQ-031 beta_ready_i low for 5 cycles in OUT -> outputs held constant, no ack; on ready high with a pending req -> ack in the same cycle.
REQ-032 rst_n pulsed low during CALC -> all outputs return to 0 asynchronously, and the next request completes normally.
